// File: rtl/cpu16_pkg.sv
// Shared types and constants for the 16-bit CPU front end.
package cpu16_pkg;

  localparam int unsigned INST_W     = 16;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'd10;
  localparam logic [ADDR_W-1:0] PC_INC   = 16'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry prefetch buffer of {pc, data}; flush has priority over push.
module fetch_fifo
  import cpu16_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  fetch_entry_t       entry_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [CNT_W-1:0]   count_o,
  output fetch_entry_t       head_o,
  output logic               empty_o
);

  fetch_entry_t           mem_q [FIFO_DEPTH];
  fetch_entry_t           mem_d [FIFO_DEPTH];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   push_ok;
  logic                   pop_ok;

  assign push_ok = push_i && (count_q != CNT_W'(FIFO_DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = entry_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, requests imem, buffers two words for decode.
module fetch_unit
  import cpu16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    count_next;
  fetch_entry_t      fifo_head;
  fetch_entry_t      fifo_in;

  assign pop        = inst_valid && inst_ready;
  assign push       = (state_q == S_REQ) && imem_ack && !redirect_valid;
  assign count_next = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
  assign fifo_in    = '{pc: fetch_pc_q, data: imem_rdata};

  // Next-state and fetch PC; a redirect overrides ack, push and pop.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      if ((state_q != S_IDLE) && !imem_ack) begin
        state_d = S_DROP;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (count_next < (CNT_W+1)'(FIFO_DEPTH)) state_d = S_REQ;
        end
        S_REQ: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
            state_d    = (count_next < (CNT_W+1)'(FIFO_DEPTH)) ? S_REQ : S_IDLE;
          end
        end
        S_DROP: begin
          if (imem_ack) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and PC registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (fifo_in),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .count_o (fifo_count),
    .head_o  (fifo_head),
    .empty_o (fifo_empty)
  );

  assign imem_req   = (state_q != S_IDLE);
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = !fifo_empty;
  assign inst_data  = fifo_head.data;
  assign inst_pc    = fifo_head.pc;

endmodule
